// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: register-address width and type,
// plus the encodings of the rt/rd destination select.
package cpu_pkg;

  localparam int REG_ADDR_W = 3;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // select=0 picks the rt field, select=1 picks the rd field
  localparam logic SEL_RT = 1'b0;
  localparam logic SEL_RD = 1'b1;

endpackage

// File: rtl/mux_3bit_rt_rd_mux2.sv
// Generic WIDTH-bit 2:1 combinational multiplexer.
// An unknown select yields an all-X result instead of quietly choosing an input.
module mux2
  import cpu_pkg::*;
#(
  parameter int WIDTH = REG_ADDR_W
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  // Select between the two candidates; X/Z on sel falls through to all-X
  always_comb begin
    y = 'x;
    case (sel)
      SEL_RT:  y = in0;
      SEL_RD:  y = in1;
      default: y = 'x;
    endcase
  end

endmodule

// File: rtl/mux_3bit_rt_rd.sv
// rt/rd destination-register select for the RISC datapath.
// out is the combinational choice feeding the register-file write address;
// out_q/sel_q are the same values registered for writeback timing.
// Optional feature: define MUX_TOGGLE_CNT_EN to add toggle_cnt, a wrapping
// count of clock edges on which select differed from the registered sel_q.
module mux_3bit_rt_rd
  import cpu_pkg::*;
#(
  parameter int WIDTH = $bits(reg_addr_t)
`ifdef MUX_TOGGLE_CNT_EN
 ,parameter int CNT_WIDTH = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input0,
  input  logic             select,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             sel_q
`ifdef MUX_TOGGLE_CNT_EN
 ,output logic [CNT_WIDTH-1:0] toggle_cnt
`endif
);

  mux2 #(
    .WIDTH(WIDTH)
  ) u_mux2 (
    .in0(input0),
    .in1(input1),
    .sel(select),
    .y  (out)
  );

  // Register the mux result and select; reset clears them without waiting for clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      sel_q <= 1'b0;
    end else begin
      out_q <= out;
      sel_q <= select;
    end
  end

`ifdef MUX_TOGGLE_CNT_EN
  // Count edges where select differs from its registered copy, wrapping naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle_cnt <= '0;
    end else if (select != sel_q) begin
      toggle_cnt <= toggle_cnt + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mux_3bit_rt_rd.sv
// Self-checking bench for mux_3bit_rt_rd: combinational select, exhaustive
// and random sweeps, registered copies, async reset, X select, and the
// optional toggle counter when MUX_TOGGLE_CNT_EN is defined.
module tb_mux_3bit_rt_rd;
  import cpu_pkg::*;

  localparam int W = REG_ADDR_W;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] input0;
  logic [W-1:0] input1;
  logic         select;
  logic [W-1:0] out;
  logic [W-1:0] out_q;
  logic         sel_q;

`ifdef MUX_TOGGLE_CNT_EN
  localparam int CW = 4;
  logic [CW-1:0] toggle_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux_3bit_rt_rd #(
    .WIDTH(W)
`ifdef MUX_TOGGLE_CNT_EN
   ,.CNT_WIDTH(CW)
`endif
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .input1(input1),
    .input0(input0),
    .select(select),
    .out   (out),
    .out_q (out_q),
    .sel_q (sel_q)
`ifdef MUX_TOGGLE_CNT_EN
   ,.toggle_cnt(toggle_cnt)
`endif
  );

  // Reference: pick the candidate indexed by select; unknown select gives all-X
  function automatic logic [W-1:0] ref_mux(input logic s, input logic [W-1:0] a0,
                                           input logic [W-1:0] a1);
    logic [W-1:0] cand [2];
    cand[0] = a0;
    cand[1] = a1;
    if ($isunknown(s)) return 'x;
    return cand[int'(s)];
  endfunction

  task automatic test_reset();
    rst = 1'b1; input0 = 3'd2; input1 = 3'd7; select = 1'b1;
    #1;
    checks++;
    if (out_q !== 3'd0 || sel_q !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_immediate: out_q=%0d sel_q=%0b, required 0/0", out_q, sel_q);
    end
    @(negedge clk);
    checks++;
    if (out_q !== 3'd0 || sel_q !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_hold: out_q=%0d sel_q=%0b, required 0/0", out_q, sel_q);
    end
    rst = 1'b0; input1 = 3'd5; input0 = 3'd2; select = 1'b1;
    #1;
    checks++;
    if (out_q !== 3'd0 || sel_q !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release_no_edge: out_q=%0d sel_q=%0b, required 0/0", out_q, sel_q);
    end
    @(negedge clk);
    checks++;
    if (out_q !== 3'd5 || sel_q !== 1'b1) begin
      errors++;
      $display("[TB] FAIL first_capture: out_q=%0d sel_q=%0b, required 5/1", out_q, sel_q);
    end
  endtask

  task automatic test_comb_basic();
    input1 = 3'd0; input0 = 3'd1; select = 1'b0;
    #1;
    checks++;
    if (out !== 3'b001) begin
      errors++;
      $display("[TB] FAIL comb_sel0: out=%b, required 001", out);
    end
    select = 1'b1;
    #1;
    checks++;
    if (out !== 3'b000) begin
      errors++;
      $display("[TB] FAIL comb_sel1: out=%b, required 000", out);
    end
  endtask

  task automatic test_sweep();
    logic [W-1:0] exp;
    for (int i = 0; i < 64; i++) begin
      for (int s = 0; s < 2; s++) begin
        input0 = W'(i % 8);
        input1 = W'(i / 8);
        select = s[0];
        #1;
        exp = ref_mux(select, input0, input1);
        checks++;
        if (out !== exp) begin
          errors++;
          $display("[TB] FAIL sweep i0=%0d i1=%0d sel=%0d: out=%0d, required %0d",
                   input0, input1, s, out, exp);
        end
      end
    end
    for (int n = 0; n < 40; n++) begin
      input0 = W'($urandom);
      input1 = W'($urandom);
      select = 1'($urandom);
      #1;
      exp = ref_mux(select, input0, input1);
      checks++;
      if (out !== exp) begin
        errors++;
        $display("[TB] FAIL random_comb: out=%0d, required %0d", out, exp);
      end
    end
  endtask

  task automatic test_pipeline();
    logic [W-1:0] exp_q;
    logic         exp_s;
    logic [W-1:0] prev_q;
    logic         prev_s;
    @(negedge clk);
    input0 = W'($urandom); input1 = W'($urandom); select = 1'($urandom);
    prev_q = ref_mux(select, input0, input1);
    prev_s = select;
    @(negedge clk);
    for (int n = 0; n < 30; n++) begin
      input0 = W'($urandom);
      input1 = W'($urandom);
      select = 1'($urandom);
      exp_q = ref_mux(select, input0, input1);
      exp_s = select;
      #1;
      checks++;
      if (out_q !== prev_q || sel_q !== prev_s) begin
        errors++;
        $display("[TB] FAIL pipe_hold: out_q=%0d sel_q=%0b, required %0d/%0b",
                 out_q, sel_q, prev_q, prev_s);
      end
      @(negedge clk);
      checks++;
      if (out_q !== exp_q || sel_q !== exp_s) begin
        errors++;
        $display("[TB] FAIL pipe_capture: out_q=%0d sel_q=%0b, required %0d/%0b",
                 out_q, sel_q, exp_q, exp_s);
      end
      prev_q = exp_q;
      prev_s = exp_s;
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    input0 = 3'd6; input1 = 3'd3; select = 1'b0;
    @(negedge clk);
    checks++;
    if (out_q !== 3'd6) begin
      errors++;
      $display("[TB] FAIL mid_pre: out_q=%0d, required 6", out_q);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_q !== 3'd0 || sel_q !== 1'b0 || out !== 3'd6) begin
      errors++;
      $display("[TB] FAIL mid_reset: out_q=%0d sel_q=%0b out=%0d, required 0/0/6",
               out_q, sel_q, out);
    end
    input0 = 3'd2;
    select = 1'b0;
    #1;
    checks++;
    if (out !== 3'd2) begin
      errors++;
      $display("[TB] FAIL mid_track: out=%0d, required 2", out);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_q !== 3'd0) begin
      errors++;
      $display("[TB] FAIL mid_hold_edge: out_q=%0d, required 0", out_q);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_q !== 3'd2 || sel_q !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_release: out_q=%0d sel_q=%0b, required 2/0", out_q, sel_q);
    end
  endtask

  task automatic test_x_select();
    input0 = 3'd4; input1 = 3'd4; select = 1'bx;
    #1;
    if ($isunknown(select)) begin
      checks++;
      if (out !== 3'bxxx) begin
        errors++;
        $display("[TB] FAIL x_select: out=%b, required xxx", out);
      end
    end
    select = 1'b0; input0 = 3'd3; input1 = 3'd1;
    #1;
    checks++;
    if (out !== 3'd3) begin
      errors++;
      $display("[TB] FAIL x_restore: out=%0d, required 3", out);
    end
  endtask

`ifdef MUX_TOGGLE_CNT_EN
  task automatic test_toggle();
    int model_cnt;
    logic held_sel;
    @(negedge clk);
    rst = 1'b1; select = 1'b0;
    #1;
    checks++;
    if (toggle_cnt !== '0) begin
      errors++;
      $display("[TB] FAIL toggle_reset: cnt=%0d, required 0", toggle_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    model_cnt = 0;
    held_sel = 1'b0;
    for (int n = 0; n < 4; n++) begin
      select = ~held_sel;
      @(negedge clk);
      if (select != held_sel) model_cnt = (model_cnt + 1) % (1 << CW);
      held_sel = select;
    end
    checks++;
    if (toggle_cnt !== CW'(4)) begin
      errors++;
      $display("[TB] FAIL toggle_four: cnt=%0d, required 4", toggle_cnt);
    end
    for (int n = 0; n < 20; n++) begin
      select = 1'($urandom);
      @(negedge clk);
      if (select != held_sel) model_cnt = (model_cnt + 1) % (1 << CW);
      held_sel = select;
      checks++;
      if (toggle_cnt !== CW'(model_cnt)) begin
        errors++;
        $display("[TB] FAIL toggle_random: cnt=%0d, required %0d", toggle_cnt, model_cnt);
      end
    end
    while (model_cnt != 0) begin
      select = ~held_sel;
      @(negedge clk);
      model_cnt = (model_cnt + 1) % (1 << CW);
      held_sel = select;
    end
    checks++;
    if (toggle_cnt !== '0) begin
      errors++;
      $display("[TB] FAIL toggle_wrap: cnt=%0d, required 0", toggle_cnt);
    end
    select = ~held_sel;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (toggle_cnt !== '0) begin
      errors++;
      $display("[TB] FAIL toggle_mid_reset: cnt=%0d, required 0", toggle_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_comb_basic();
    test_sweep();
    test_pipeline();
    test_reset_mid();
    test_x_select();
`ifdef MUX_TOGGLE_CNT_EN
    test_toggle();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
